prefix_accum: RTL and testbench

Sequential x86 prefix accumulator between the fetch byte stream and the opcode decoder. Consumes one instruction byte per cycle over a valid/ready handshake, classifies legacy prefixes (REP, REPNE, six segment overrides, operand-size, optional LOCK) and accumulates them up to a parametrised maximum. On the first non-prefix byte it presents one registered record to decode: the opcode byte, the merged prefix state and the prefix count. It faults if an instruction carries more prefixes than the maximum.

---
 rtl/prefix_pkg.sv | 29 ++
 rtl/prefix_accum_if.sv | 33 +++
 rtl/prefix_classify.sv | 39 +++
 rtl/prefix_accum.sv | 131 +++++++++++++
 tb/tb_prefix_accum.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/prefix_pkg.sv
// Shared constants for the x86 legacy-prefix accumulator: prefix byte values,
// segment one-hot bit positions and the SCAN/HOLD state encoding.
package prefix_pkg;

   localparam logic [7:0] PFX_REP    = 8'hF3;
   localparam logic [7:0] PFX_REPNE  = 8'hF2;
   localparam logic [7:0] PFX_CS     = 8'h2E;
   localparam logic [7:0] PFX_SS     = 8'h36;
   localparam logic [7:0] PFX_DS     = 8'h3E;
   localparam logic [7:0] PFX_ES     = 8'h26;
   localparam logic [7:0] PFX_FS     = 8'h64;
   localparam logic [7:0] PFX_GS     = 8'h65;
   localparam logic [7:0] PFX_OPSIZE = 8'h66;
   localparam logic [7:0] PFX_LOCK   = 8'hF0;

   localparam int SEG_W  = 6;
   localparam int SEG_CS = 0;
   localparam int SEG_SS = 1;
   localparam int SEG_DS = 2;
   localparam int SEG_ES = 3;
   localparam int SEG_FS = 4;
   localparam int SEG_GS = 5;

   typedef enum logic {
      SCAN = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/prefix_accum_if.sv
// Byte-stream input and decode-record output of the prefix accumulator.
// slave = accumulator side, master = fetch/decode side.
interface prefix_accum_if
   import prefix_pkg::*;
#(
   parameter int CNT_W = 3
);
   logic             in_valid;
   logic [7:0]       in_byte;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_opcode;
   logic             out_rep;
   logic             out_repne;
   logic [SEG_W-1:0] out_seg;
   logic             out_opsize;
   logic             out_lock;
   logic [CNT_W-1:0] out_pcount;
   logic             out_fault;

   modport slave (
      input  in_valid, in_byte, out_ready,
      output in_ready, out_valid, out_opcode, out_rep, out_repne, out_seg,
             out_opsize, out_lock, out_pcount, out_fault
   );

   modport master (
      output in_valid, in_byte, out_ready,
      input  in_ready, out_valid, out_opcode, out_rep, out_repne, out_seg,
             out_opsize, out_lock, out_pcount, out_fault
   );
endinterface

// File: rtl/prefix_classify.sv
// Combinational legacy-prefix decode of one instruction byte.
// F0 is recognised as LOCK only when PREFIX_LOCK_EN is defined.
module prefix_classify
   import prefix_pkg::*;
(
   input  logic [7:0]       in_byte,
   output logic             is_prefix,
   output logic             is_rep,
   output logic             is_repne,
   output logic [SEG_W-1:0] seg,
   output logic             is_opsize,
   output logic             is_lock
);

   always_comb begin
      is_rep    = 1'b0;
      is_repne  = 1'b0;
      seg       = '0;
      is_opsize = 1'b0;
      is_lock   = 1'b0;
      case (in_byte)
         PFX_REP:    is_rep         = 1'b1;
         PFX_REPNE:  is_repne       = 1'b1;
         PFX_CS:     seg[SEG_CS]    = 1'b1;
         PFX_SS:     seg[SEG_SS]    = 1'b1;
         PFX_DS:     seg[SEG_DS]    = 1'b1;
         PFX_ES:     seg[SEG_ES]    = 1'b1;
         PFX_FS:     seg[SEG_FS]    = 1'b1;
         PFX_GS:     seg[SEG_GS]    = 1'b1;
         PFX_OPSIZE: is_opsize      = 1'b1;
`ifdef PREFIX_LOCK_EN
         PFX_LOCK:   is_lock        = 1'b1;
`endif
         default: ;
      endcase
      is_prefix = is_rep | is_repne | (|seg) | is_opsize | is_lock;
   end

endmodule

// File: rtl/prefix_accum.sv
// Accumulates legacy prefixes and emits one registered record per instruction
// one cycle after its opcode is accepted; in_ready drops while the record waits.
module prefix_accum
   import prefix_pkg::*;
#(
   parameter int MAX_PREFIX = 4,
   parameter int CNT_W      = 3
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   prefix_accum_if.slave  bus
);

   logic             cls_prefix, cls_rep, cls_repne, cls_opsize, cls_lock;
   logic [SEG_W-1:0] cls_seg;

   prefix_classify u_classify (
      .in_byte   (bus.in_byte),
      .is_prefix (cls_prefix),
      .is_rep    (cls_rep),
      .is_repne  (cls_repne),
      .seg       (cls_seg),
      .is_opsize (cls_opsize),
      .is_lock   (cls_lock)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rep_q, rep_d, repne_q, repne_d;
   logic [SEG_W-1:0] seg_q, seg_d;
   logic             opsize_q, opsize_d, lock_q, lock_d;
   logic [7:0]       opcode_q, opcode_d;
   logic             fault_q, fault_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SCAN;
         cnt_q    <= '0;
         rep_q    <= 1'b0;
         repne_q  <= 1'b0;
         seg_q    <= '0;
         opsize_q <= 1'b0;
         lock_q   <= 1'b0;
         opcode_q <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rep_q    <= rep_d;
         repne_q  <= repne_d;
         seg_q    <= seg_d;
         opsize_q <= opsize_d;
         lock_q   <= lock_d;
         opcode_q <= opcode_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rep_d    = rep_q;
      repne_d  = repne_q;
      seg_d    = seg_q;
      opsize_d = opsize_q;
      lock_d   = lock_q;
      opcode_d = opcode_q;
      fault_d  = fault_q;
      case (state_q)
         SCAN: begin
            if (bus.in_valid) begin
               if (cls_prefix && cnt_q == CNT_W'(MAX_PREFIX)) begin
                  // Overflow: record keeps the prefixes merged so far.
                  opcode_d = bus.in_byte;
                  fault_d  = 1'b1;
                  state_d  = HOLD;
               end else if (cls_prefix) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cls_rep)   begin rep_d = 1'b1; repne_d = 1'b0; end
                  if (cls_repne) begin rep_d = 1'b0; repne_d = 1'b1; end
                  if (|cls_seg)  seg_d = cls_seg;
                  if (cls_opsize) opsize_d = 1'b1;
                  if (cls_lock)   lock_d   = 1'b1;
               end else begin
                  opcode_d = bus.in_byte;
                  state_d  = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d  = SCAN;
               cnt_d    = '0;
               rep_d    = 1'b0;
               repne_d  = 1'b0;
               seg_d    = '0;
               opsize_d = 1'b0;
               lock_d   = 1'b0;
               opcode_d = '0;
               fault_d  = 1'b0;
            end
         end
         default: state_d = SCAN;
      endcase
      // Flush beats everything, including a record handshaken this cycle.
      if (flush) begin
         state_d  = SCAN;
         cnt_d    = '0;
         rep_d    = 1'b0;
         repne_d  = 1'b0;
         seg_d    = '0;
         opsize_d = 1'b0;
         lock_d   = 1'b0;
         opcode_d = '0;
         fault_d  = 1'b0;
      end
   end

   assign bus.in_ready   = (state_q == SCAN);
   assign bus.out_valid  = (state_q == HOLD);
   assign bus.out_opcode = opcode_q;
   assign bus.out_rep    = rep_q;
   assign bus.out_repne  = repne_q;
   assign bus.out_seg    = seg_q;
   assign bus.out_opsize = opsize_q;
   assign bus.out_lock   = lock_q;
   assign bus.out_pcount = cnt_q;
   assign bus.out_fault  = fault_q;

endmodule

// File: tb/tb_prefix_accum.sv
// Directed-vector bench for prefix_accum with hand-computed records.
module tb_prefix_accum;
   import prefix_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   checks = 0;
   int   failures = 0;

   prefix_accum_if #(.CNT_W(3)) bus ();

   prefix_accum #(.MAX_PREFIX(4), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      check("push_rdy", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_byte  = b;
      tick();
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;
   endtask

   // flags = {rep, repne, seg[5:0], opsize, lock}
   task automatic chk_rec(input string tag, input logic [7:0] opc, input logic [9:0] flags,
                          input logic [2:0] pc, input logic flt);
      check({tag, ".vld"},   32'(bus.out_valid), 32'd1);
      check({tag, ".rdy"},   32'(bus.in_ready), 32'd0);
      check({tag, ".opc"},   32'(bus.out_opcode), 32'(opc));
      check({tag, ".flags"}, 32'({bus.out_rep, bus.out_repne, bus.out_seg, bus.out_opsize, bus.out_lock}),
            32'(flags));
      check({tag, ".pcnt"},  32'(bus.out_pcount), 32'(pc));
      check({tag, ".fault"}, 32'(bus.out_fault), 32'(flt));
   endtask

   function automatic logic [31:0] all_out();
      return {bus.out_valid, bus.in_ready, bus.out_opcode, bus.out_rep, bus.out_repne, bus.out_seg,
              bus.out_opsize, bus.out_lock, bus.out_pcount, bus.out_fault};
   endfunction

   // in_ready=1 with everything else zero
   localparam logic [31:0] IDLE = 32'h0040_0000;

   task automatic pop(input string tag);
      tick();
      check({tag, ".idle"}, all_out(), IDLE);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_byte   = 8'h00;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold", all_out(), IDLE);
      rst_n = 1'b1;
      tick();
      check("rst_state", all_out(), IDLE);

      // CS, opsize, REP, MOVS
      push(8'h2E); push(8'h66); push(8'hF3); push(8'hA5);
      chk_rec("movs", 8'hA5, {1'b1, 1'b0, 6'b000001, 1'b1, 1'b0}, 3'd3, 1'b0);
      pop("movs");

      // REPNE then REP: REP wins; ES then FS: FS wins
      push(8'hF2); push(8'hF3); push(8'h26); push(8'h64); push(8'hAC);
      chk_rec("lods", 8'hAC, {1'b1, 1'b0, 6'b010000, 1'b0, 1'b0}, 3'd4, 1'b0);
      pop("lods");

      // REP then REPNE: REPNE wins
      push(8'hF3); push(8'hF2); push(8'hA6);
      chk_rec("cmps", 8'hA6, {1'b0, 1'b1, 6'b000000, 1'b0, 1'b0}, 3'd2, 1'b0);
      pop("cmps");

      // Fifth prefix overflows
      push(8'h66); push(8'h66); push(8'h66); push(8'h66); push(8'h2E);
      chk_rec("ovf", 8'h2E, {1'b0, 1'b0, 6'b000000, 1'b1, 1'b0}, 3'd4, 1'b1);
      pop("ovf");

      // Exactly MAX prefixes is legal
      push(8'h36); push(8'h3E); push(8'h65); push(8'h66); push(8'h8B);
      chk_rec("max", 8'h8B, {1'b0, 1'b0, 6'b100000, 1'b1, 1'b0}, 3'd4, 1'b0);
      pop("max");

      // Backpressure: record held 5 cycles while a byte is offered
      bus.out_ready = 1'b0;
      push(8'h2E); push(8'h48);
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'h90;
      for (int i = 0; i < 5; i++) begin
         chk_rec("stall", 8'h48, {1'b0, 1'b0, 6'b000001, 1'b0, 1'b0}, 3'd1, 1'b0);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("stall.rel", all_out(), IDLE);
      push(8'h90);
      chk_rec("nop", 8'h90, 10'd0, 3'd0, 1'b0);
      pop("nop");

      // Prefix held across bubbles
      push(8'h26);
      repeat (3) tick();
      push(8'h90);
      chk_rec("bubble", 8'h90, {1'b0, 1'b0, 6'b001000, 1'b0, 1'b0}, 3'd1, 1'b0);
      pop("bubble");

      // Flush mid-prefix drops the byte offered with it
      push(8'h3E); push(8'h66);
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'h90;
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("flush.scan", all_out(), IDLE);
      push(8'hC3);
      chk_rec("ret", 8'hC3, 10'd0, 3'd0, 1'b0);
      pop("ret");

      // Flush while a record is pending, even with out_ready high
      push(8'h64); push(8'hCC);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush.hold", all_out(), IDLE);

      // LOCK
      push(8'hF0);
`ifdef PREFIX_LOCK_EN
      push(8'h90);
      chk_rec("lock", 8'h90, {1'b0, 1'b0, 6'b000000, 1'b0, 1'b1}, 3'd1, 1'b0);
      pop("lock");
`else
      chk_rec("f0op", 8'hF0, 10'd0, 3'd0, 1'b0);
      pop("f0op");
      push(8'h90);
      chk_rec("f0nop", 8'h90, 10'd0, 3'd0, 1'b0);
      pop("f0nop");
`endif

      // Reset mid-stream loses partial prefixes
      push(8'h66);
      rst_n = 1'b0;
      #2;
      check("rst_mid", all_out(), IDLE);
      tick();
      rst_n = 1'b1;
      push(8'h90);
      chk_rec("post_rst", 8'h90, 10'd0, 3'd0, 1'b0);
      pop("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
